// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: feeds a DSP multiply-accumulate element from a valid/ready
// stream of signed operand pairs, then collects one accumulator value per vector
// into a first-word-fall-through result FIFO.
//
// The MAC element has no stall input. A beat is accepted only when the FIFO has a
// reserved slot for every vector result still in flight, so no result is ever lost.
//
// Optional build macro: DSP_SEQ_SAT_EN
//   - defined   : result = mac_acc saturated to the signed OUT_SIZE range
//   - undefined : result = mac_acc[OUT_SIZE-1:0] (wrap-around truncation)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_op0/s_op1/s_last        input operand pair and end-of-vector flag
//   s_valid/s_ready           input handshake
//   mac_op0/op1/op2           MAC operands (op2 is tied to zero)
//   mac_bypass_mlt            MAC multiplier bypass (tied to 0)
//   mac_bypass_add            1 = MAC accumulator holds its value
//   mac_reset_acc             1 = MAC loads the product instead of adding it
//   mac_tag_out/mac_tag_in    sideband tag to/from MAC: {last, beat valid}
//   mac_acc                   MAC accumulator value
//   m_data/m_valid/m_ready    result stream
module dsp_mac_sequencer #(
   parameter int unsigned OP0_SIZE       = 8,
   parameter int unsigned OP1_SIZE       = 8,
   parameter int unsigned ACC_SIZE       = 24,
   parameter int unsigned OUT_SIZE       = 16,
   parameter int unsigned RES_FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OP0_SIZE-1:0] s_op0,
   input  logic [OP1_SIZE-1:0] s_op1,
   input  logic                s_last,
   input  logic                s_valid,
   output logic                s_ready,
   output logic [OP0_SIZE-1:0] mac_op0,
   output logic [OP1_SIZE-1:0] mac_op1,
   output logic [ACC_SIZE-1:0] mac_op2,
   output logic                mac_bypass_mlt,
   output logic                mac_bypass_add,
   output logic                mac_reset_acc,
   output logic [1:0]          mac_tag_out,
   input  logic [1:0]          mac_tag_in,
   input  logic [ACC_SIZE-1:0] mac_acc,
   output logic [OUT_SIZE-1:0] m_data,
   output logic                m_valid,
   input  logic                m_ready
);

   localparam int unsigned PTR_W = $clog2(RES_FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(RES_FIFO_DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(RES_FIFO_DEPTH);

   typedef enum logic {
      ST_FIRST,
      ST_ACCUM
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                accept;
   logic                cap_pending;
   logic [CNT_W-1:0]    inflight;
   logic [CNT_W-1:0]    fifo_count;
   logic [CNT_W:0]      occupied;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic                fifo_wr;
   logic                fifo_rd;
   logic [OUT_SIZE-1:0] result;
   logic [OUT_SIZE-1:0] mem [RES_FIFO_DEPTH];

   // Credit check: results in flight plus buffered results must leave a free slot.
   assign occupied = {1'b0, inflight} + {1'b0, fifo_count};
   assign s_ready  = !rst && (occupied < DEPTH_C);
   assign accept   = s_valid && s_ready;

   assign mac_op2        = '0;
   assign mac_bypass_mlt = 1'b0;

   // Accumulator reduction to the output width.
`ifdef DSP_SEQ_SAT_EN
   localparam logic [ACC_SIZE-1:0] SAT_MAX =
      {{(ACC_SIZE - OUT_SIZE + 1){1'b0}}, {(OUT_SIZE - 1){1'b1}}};
   localparam logic [ACC_SIZE-1:0] SAT_MIN = ~SAT_MAX;

   always_comb begin
      result = mac_acc[OUT_SIZE-1:0];
      if ($signed(mac_acc) > $signed(SAT_MAX)) begin
         result = {1'b0, {(OUT_SIZE - 1){1'b1}}};
      end else if ($signed(mac_acc) < $signed(SAT_MIN)) begin
         result = {1'b1, {(OUT_SIZE - 1){1'b0}}};
      end
   end
`else
   logic unused_acc_msbs;
   assign result          = mac_acc[OUT_SIZE-1:0];
   assign unused_acc_msbs = ^mac_acc[ACC_SIZE-1:OUT_SIZE];
`endif

   // Vector FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_FIRST;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and MAC drive; with no accepted beat the accumulator holds.
   always_comb begin
      state_nxt      = state;
      mac_op0        = '0;
      mac_op1        = '0;
      mac_bypass_add = 1'b1;
      mac_reset_acc  = 1'b0;
      mac_tag_out    = 2'b00;
      if (accept) begin
         mac_op0        = s_op0;
         mac_op1        = s_op1;
         mac_bypass_add = 1'b0;
         mac_reset_acc  = (state == ST_FIRST);
         mac_tag_out    = {s_last, 1'b1};
         state_nxt      = s_last ? ST_FIRST : ST_ACCUM;
      end
   end

   // The accumulator settles one cycle after the last tag returns.
   assign fifo_wr = cap_pending;
   assign fifo_rd = m_valid && m_ready;

   // Capture, credit and FIFO bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_pending <= 1'b0;
         inflight    <= '0;
         fifo_count  <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         cap_pending <= (mac_tag_in == 2'b11);
         inflight    <= inflight + CNT_W'(accept && s_last) - CNT_W'(cap_pending);
         fifo_count  <= fifo_count + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
         if (fifo_wr) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (fifo_rd) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Result storage; contents are only observable while the FIFO is non-empty.
   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         mem[wr_ptr] <= result;
      end
   end

   assign m_valid = (fifo_count != '0);
   assign m_data  = m_valid ? mem[rd_ptr] : '0;

endmodule
